ser2par_collector: RTL
======================

SER2PAR_COLLECTOR -- requirements
Module: ser2par_collector

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data bits per assembled word (2..32).
REQ-002 SHALL have parameter DEPTH, default 4, output FIFO entries (power of 2, >=2).
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port din_vld  input  1  serial bit strobe; din sampled only when high.
REQ-006 SHALL have port din  input  1  serial data bit, LSB first (fed by the registered DFF stage output).
REQ-007 SHALL have port sof  input  1  start-of-frame; qualifies din_vld bit as bit 0.
REQ-008 SHALL have port dout  output  WIDTH  FIFO head word.
REQ-009 SHALL have port dout_vld  output  1  FIFO not empty.
REQ-010 SHALL have port dout_rdy  input  1  consumer accept; pop when dout_vld && dout_rdy.
REQ-011 SHALL have port level  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-012 SHALL have port ovf  output  1  sticky overflow flag.
REQ-013 SHALL have port par_err  output  1  sticky parity error flag.
REQ-014 SHALL have port clr_err  input  1  synchronous clear of ovf and par_err.

Function
REQ-015 SHALL keep bit counter 0..N-1 (N=WIDTH, or WIDTH+1 with parity); increment only on din_vld; wrap to 0 after N-1.
REQ-016 SHALL store din into shift register position equal to bit counter on each din_vld.
REQ-017 SHALL, on din_vld && sof, discard any partial word, store din as bit 0, set counter to 1.
REQ-018 SHALL ignore sof when din_vld low.
REQ-019 SHALL push the completed word into FIFO on the edge sampling bit N-1; dout_vld high from that edge (one-cycle latency, last bit to visible word).
REQ-020 SHALL present FIFO head on dout combinationally from storage; dout undefined-free (holds last head value, reset 0) when empty.
REQ-021 SHALL pop on dout_vld && dout_rdy; dout_rdy while empty has no effect.
REQ-022 SHALL, on push while level==DEPTH without same-cycle pop, drop the word, leave FIFO unchanged, set ovf.
REQ-023 SHALL, on push and pop in the same cycle while full, accept both; level unchanged; ovf not set.
REQ-024 SHALL, on push and pop in the same cycle while empty, only push (no pop of empty).
REQ-025 SHALL wrap read/write pointers modulo DEPTH; level = writes minus reads, 0..DEPTH.
REQ-026 SHALL clear ovf and par_err on clr_err; a same-cycle set event wins over clear.

Reset
REQ-027 SHALL, while rst low, asynchronously force counter=0, shift register=0, pointers=0, level=0, dout=0, dout_vld=0, ovf=0, par_err=0.
REQ-028 SHALL discard any partial word and all FIFO contents on reset mid-operation; first bit after release is bit 0.

Configuration
REQ-029 SHALL compile parity support only when macro SER2PAR_PARITY_EN is defined.
REQ-030 SHALL, with SER2PAR_PARITY_EN, expect one even-parity bit after WIDTH data bits (N=WIDTH+1), push word on parity bit, set par_err if XOR of data and parity bit is 1; word pushed regardless.
REQ-031 SHALL, without SER2PAR_PARITY_EN, use N=WIDTH, drive par_err constant 0.

Verification
REQ-032 Reset release, sof on first of bits 1,0,1,0,0,1,0,1 with dout_rdy=0 -> dout=8'hA5, dout_vld high cycle after 8th bit, level=1.
REQ-033 Five words 8'h01..8'h05 with dout_rdy=0, DEPTH=4 -> level=4, 5th dropped, ovf=1; pops return 01,02,03,04; clr_err -> ovf=0.
REQ-034 3 bits then sof with new word 8'h3C -> only 8'h3C pushed, level=1.
REQ-035 FIFO full, dout_rdy=1 held while 8'h77 completes -> head popped, 8'h77 enqueued, level stays 4, ovf=0.
REQ-036 SER2PAR_PARITY_EN: 8'hA5 + parity 0 -> par_err=0; 8'hA5 + parity 1 -> par_err=1, both words pushed; without macro par_err=0 throughout.
REQ-037 rst low mid-word (bit 4) and with level=2 -> all outputs 0 immediately; next 8 bits form new word correctly.

Source files
------------

// File: rtl/ser2par_collector.sv
// Serial-to-parallel word collector with a DEPTH-entry output FIFO and sticky error flags.
// Define SER2PAR_PARITY_EN to expect an even-parity bit after each WIDTH data bits.
module ser2par_collector #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     din_vld,
   input  logic                     din,
   input  logic                     sof,
   output logic [WIDTH-1:0]         dout,
   output logic                     dout_vld,
   input  logic                     dout_rdy,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     ovf,
   output logic                     par_err,
   input  logic                     clr_err
);

`ifdef SER2PAR_PARITY_EN
   localparam int N = WIDTH + 1;
`else
   localparam int N = WIDTH;
`endif
   localparam int CW = $clog2(N + 1);
   localparam int AW = $clog2(DEPTH);

   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_shift;
   logic [CW-1:0]    w_idx;
   logic [WIDTH-1:0] w_shift_nxt;
   logic             w_push;

   // sof restarts the word: the qualifying bit is always bit 0.
   always_comb begin
      w_idx       = sof ? '0 : r_cnt;
      w_shift_nxt = sof ? '0 : r_shift;
      for (int i = 0; i < WIDTH; i++) begin
         if (w_idx == CW'(i)) w_shift_nxt[i] = din;
      end
      w_push = din_vld && (w_idx == CW'(N - 1));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt   <= '0;
         r_shift <= '0;
      end else if (din_vld) begin
         r_cnt   <= w_push ? '0 : w_idx + 1'b1;
         r_shift <= w_push ? '0 : w_shift_nxt;
      end
   end

   // Output handshake: a word transfers on any edge where dout_vld && dout_rdy;
   // dout_vld only drops after the transfer that empties the FIFO.
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wp, r_rp;
   logic [AW:0]      r_level;
   logic             r_ovf;
   logic             w_pop, w_full, w_wr, w_ovf_set;
   logic [AW-1:0]    w_rp_prev;

   assign w_pop     = (r_level != '0) && dout_rdy;
   assign w_full    = (r_level == (AW+1)'(DEPTH));
   assign w_wr      = w_push && (!w_full || w_pop);
   assign w_ovf_set = w_push && w_full && !w_pop;
   assign w_rp_prev = r_rp - 1'b1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_wp    <= '0;
         r_rp    <= '0;
         r_level <= '0;
         r_ovf   <= 1'b0;
      end else begin
         if (w_wr) begin
            r_mem[r_wp] <= w_shift_nxt;
            r_wp        <= r_wp + 1'b1;
         end
         if (w_pop) r_rp <= r_rp + 1'b1;
         if (w_wr && !w_pop)      r_level <= r_level + 1'b1;
         else if (!w_wr && w_pop) r_level <= r_level - 1'b1;
         r_ovf <= w_ovf_set | (r_ovf & ~clr_err);
      end
   end

   // When empty, the slot just behind the read pointer is the last word popped (0 after reset).
   assign dout     = (r_level == '0) ? r_mem[w_rp_prev] : r_mem[r_rp];
   assign dout_vld = (r_level != '0);
   assign level    = r_level;
   assign ovf      = r_ovf;

`ifdef SER2PAR_PARITY_EN
   logic r_par_err;
   logic w_par_set;

   // On the parity bit r_shift still holds all data bits.
   assign w_par_set = w_push && ((^r_shift) ^ din);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_par_err <= 1'b0;
      else      r_par_err <= w_par_set | (r_par_err & ~clr_err);
   end
   assign par_err = r_par_err;
`else
   assign par_err = 1'b0;
`endif

endmodule
